// File: rtl/fpu_cvt_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module     : fpu_cvt_arbiter_if
//  Description: Bundle of requester, conversion-unit and response signals
//               around the shared float/int conversion arbiter.
//               master = arbiter side, slave = requesters + unit side.
//  Revision   : 1.0  initial release
// ============================================================================
interface fpu_cvt_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32
);
    localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // requester issue side
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [5*N_REQ-1:0]      req_op;
    logic [3*N_REQ-1:0]      req_rm;
    logic [DATA_W*N_REQ-1:0] req_data;

    // conversion unit operation side
    logic                    unit_valid_in;
    logic                    unit_ready_out;
    logic [4:0]              unit_op;
    logic [2:0]              unit_rm;
    logic [DATA_W-1:0]       unit_data;

    // conversion unit result side
    logic                    unit_valid_out;
    logic                    unit_ready_in;
    logic [DATA_W-1:0]       unit_result;
    logic [4:0]              unit_flags;

    // requester response side
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]       rsp_result;
    logic [4:0]              rsp_flags;
    logic [OWNER_W-1:0]      owner;
    logic                    err;

    modport master (
        input  req_valid, req_op, req_rm, req_data,
        output req_ready,
        output unit_valid_in, unit_op, unit_rm, unit_data,
        input  unit_ready_out,
        input  unit_valid_out, unit_result, unit_flags,
        output unit_ready_in,
        output rsp_valid, rsp_result, rsp_flags, owner, err,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_op, req_rm, req_data,
        input  req_ready,
        input  unit_valid_in, unit_op, unit_rm, unit_data,
        output unit_ready_out,
        output unit_valid_out, unit_result, unit_flags,
        input  unit_ready_in,
        input  rsp_valid, rsp_result, rsp_flags, owner, err,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/fpu_cvt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : fpu_cvt_arbiter
//  Description: Round-robin arbiter sharing one in-order float/int conversion
//               unit between N_REQ requesters. A small tag FIFO remembers the
//               owner of every in-flight operation so results are steered back
//               to the requester that issued them. Zero added latency.
//  Revision   : 1.0  initial release
// ============================================================================
module fpu_cvt_arbiter #(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fpu_cvt_arbiter_if.master  bus
);
    localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W   = $clog2(TAG_DEPTH + 1);

    localparam logic [CNT_W-1:0]   c_tag_depth = CNT_W'(TAG_DEPTH);
    localparam logic [PTR_W-1:0]   c_last_ptr  = PTR_W'(TAG_DEPTH - 1);
    localparam logic [OWNER_W-1:0] c_last_req  = OWNER_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [OWNER_W-1:0] r_rr_ptr;
    logic [OWNER_W-1:0] r_tag_fifo [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_gnt_any;
    logic [OWNER_W-1:0] w_gnt_idx;
    logic               w_nonempty;
    logic [OWNER_W-1:0] w_owner;
    logic               w_owner_ready;
    logic               w_pop;
    logic               w_can_issue;
    logic               w_issue;
    logic               w_unit_ready_in;

    assign w_nonempty = (r_count != '0);
    assign w_owner    = r_tag_fifo[r_rd_ptr];

    // Round-robin search starting at r_rr_ptr, wrapping modulo N_REQ
    always_comb begin : p_grant
        int                 cand;
        logic [OWNER_W-1:0] cand_idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(r_rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = OWNER_W'(cand);
            if (!w_gnt_any && bus.req_valid[cand_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = cand_idx;
            end
        end
    end

    // Look up the response-accept bit of the requester owning the FIFO head
    always_comb begin : p_owner_ready
        w_owner_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_owner == OWNER_W'(i)) begin
                w_owner_ready = bus.rsp_ready[i];
            end
        end
    end

    // Result handshake back to the unit; a result with no tracked owner is never taken
    assign w_unit_ready_in = !reset && w_nonempty && w_owner_ready;
    assign w_pop           = bus.unit_valid_out && w_unit_ready_in;

    // A full FIFO still accepts an issue when the head is retiring this cycle
    assign w_can_issue = (r_count < c_tag_depth) || w_pop;
    assign w_issue     = !reset && w_gnt_any && w_can_issue && bus.unit_ready_out;

    assign bus.unit_valid_in = !reset && w_gnt_any && w_can_issue;
    assign bus.unit_ready_in = w_unit_ready_in;

    // Forward the granted requester's operation; zeros when nobody is granted
    always_comb begin : p_op_mux
        bus.unit_op   = '0;
        bus.unit_rm   = '0;
        bus.unit_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_any && (w_gnt_idx == OWNER_W'(i))) begin
                bus.unit_op   = bus.req_op[5*i +: 5];
                bus.unit_rm   = bus.req_rm[3*i +: 3];
                bus.unit_data = bus.req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Only the granted requester sees ready, and only when issue can proceed
    always_comb begin : p_req_ready
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!reset && w_gnt_any && (w_gnt_idx == OWNER_W'(i))) begin
                bus.req_ready[i] = w_can_issue && bus.unit_ready_out;
            end
        end
    end

    // Steer the result-valid to the owner of the oldest in-flight operation
    always_comb begin : p_rsp_valid
        bus.rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_owner == OWNER_W'(i)) begin
                bus.rsp_valid[i] = !reset && bus.unit_valid_out && w_nonempty;
            end
        end
    end

    assign bus.rsp_result = bus.unit_result;
    assign bus.rsp_flags  = bus.unit_flags;
    assign bus.owner      = w_owner;
    assign bus.err        = r_err;

    // Advance round-robin priority to just past the requester that issued
    always_ff @(posedge clk or posedge reset) begin : p_rr_ptr
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_gnt_idx == c_last_req) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Tag FIFO storage: record the owner of each issued operation
    always_ff @(posedge clk or posedge reset) begin : p_tag_store
        if (reset) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag_fifo[i] <= '0;
            end
        end else if (w_issue) begin
            r_tag_fifo[r_wr_ptr] <= w_gnt_idx;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or posedge reset) begin : p_tag_ptrs
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_issue) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_issue && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_issue && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky flag for a unit result arriving with nothing outstanding
    always_ff @(posedge clk or posedge reset) begin : p_err
        if (reset) begin
            r_err <= 1'b0;
        end else if (bus.unit_valid_out && !w_nonempty) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_cvt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : tb_fpu_cvt_arbiter
//  Description: Directed self-checking bench for fpu_cvt_arbiter
//               (N_REQ=2, DATA_W=32, TAG_DEPTH=2).
//  Revision   : 1.0  initial release
// ============================================================================
module tb_fpu_cvt_arbiter;
    localparam int N_REQ     = 2;
    localparam int DATA_W    = 32;
    localparam int TAG_DEPTH = 2;

    localparam logic [31:0] c_d0 = 32'h3F80_0000;
    localparam logic [31:0] c_d1 = 32'hC000_0000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fpu_cvt_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    fpu_cvt_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req_valid      = 2'b11;
        bus.req_op         = {5'h0D, 5'h0C};
        bus.req_rm         = {3'b001, 3'b000};
        bus.req_data       = {c_d1, 32'h4049_0FDB};
        bus.unit_ready_out = 1'b1;
        bus.unit_valid_out = 1'b1;
        bus.unit_result    = 32'h0;
        bus.unit_flags     = 5'h0;
        bus.rsp_ready      = 2'b11;

        // Outputs held quiet while reset is asserted
        #3;
        chk("rst_req_ready",     32'(bus.req_ready),     32'h0);
        chk("rst_unit_valid_in", 32'(bus.unit_valid_in), 32'h0);
        chk("rst_rsp_valid",     32'(bus.rsp_valid),     32'h0);
        chk("rst_unit_ready_in", 32'(bus.unit_ready_in), 32'h0);
        chk("rst_err",           32'(bus.err),           32'h0);
        bus.req_valid      = 2'b00;
        bus.unit_valid_out = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single requester: pass-through in the same cycle
        step();
        bus.req_valid = 2'b01;
        #1;
        chk("t1_unit_valid_in", 32'(bus.unit_valid_in), 32'h1);
        chk("t1_unit_data",     bus.unit_data,          32'h4049_0FDB);
        chk("t1_unit_op",       32'(bus.unit_op),       32'h0C);
        chk("t1_req_ready",     32'(bus.req_ready),     32'h1);
        step();
        bus.req_valid      = 2'b00;
        bus.unit_valid_out = 1'b1;
        bus.unit_result    = 32'h0000_0003;
        bus.unit_flags     = 5'b00001;
        bus.req_data       = {c_d1, c_d0};
        #1;
        chk("t1_rsp_valid",     32'(bus.rsp_valid),     32'h1);
        chk("t1_owner",         32'(bus.owner),         32'h0);
        chk("t1_rsp_result",    bus.rsp_result,         32'h3);
        chk("t1_rsp_flags",     32'(bus.rsp_flags),     32'h1);
        chk("t1_unit_ready_in", 32'(bus.unit_ready_in), 32'h1);
        chk("t1_no_grant_data", bus.unit_data,          32'h0);
        step();

        // Both valid: priority now at req1, then alternates; results follow order
        bus.unit_valid_out = 1'b0;
        bus.req_valid      = 2'b11;
        #1;
        chk("rr_c0_data",      bus.unit_data,      c_d1);
        chk("rr_c0_req_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.unit_valid_out = 1'b1;
        bus.unit_result    = 32'h0000_0011;
        #1;
        chk("rr_c1_data",      bus.unit_data,      c_d0);
        chk("rr_c1_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rr_c1_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("rr_c1_owner",     32'(bus.owner),     32'h1);
        step();
        bus.unit_result = 32'h0000_0022;
        #1;
        chk("rr_c2_data",      bus.unit_data,      c_d1);
        chk("rr_c2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        step();
        bus.req_valid   = 2'b00;
        bus.unit_result = 32'h0000_0033;
        #1;
        chk("rr_c3_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("rr_c3_result",    bus.rsp_result,     32'h33);
        step();

        // Backpressure: fill both tags, then pop and issue together
        bus.unit_valid_out = 1'b0;
        bus.rsp_ready      = 2'b00;
        bus.req_valid      = 2'b11;
        #1;
        chk("bp_c0_req_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.unit_valid_out = 1'b1;
        bus.unit_result    = 32'h0000_0044;
        #1;
        chk("bp_c1_req_ready",     32'(bus.req_ready),     32'h2);
        chk("bp_c1_rsp_valid",     32'(bus.rsp_valid),     32'h1);
        chk("bp_c1_unit_ready_in", 32'(bus.unit_ready_in), 32'h0);
        step();
        chk("bp_full_req_ready",  32'(bus.req_ready),     32'h0);
        chk("bp_full_unit_valid", 32'(bus.unit_valid_in), 32'h0);
        step();
        step();
        chk("bp_hold_req_ready", 32'(bus.req_ready), 32'h0);
        bus.rsp_ready = 2'b01;
        #1;
        chk("bp_pop_unit_ready_in", 32'(bus.unit_ready_in), 32'h1);
        chk("bp_pop_unit_valid_in", 32'(bus.unit_valid_in), 32'h1);
        chk("bp_pop_req_ready",     32'(bus.req_ready),     32'h1);
        step();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        #1;
        chk("bp_drain0_owner",     32'(bus.owner),     32'h1);
        chk("bp_drain0_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        step();
        chk("bp_drain1_owner", 32'(bus.owner), 32'h0);
        step();
        bus.unit_valid_out = 1'b0;

        // Fairness: req1 appears after req0 issues and wins next
        bus.req_valid = 2'b01;
        #1;
        chk("fair_c0_req_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b11;
        #1;
        chk("fair_c1_req_ready", 32'(bus.req_ready), 32'h2);
        chk("fair_c1_data",      bus.unit_data,      c_d1);
        step();
        bus.req_valid      = 2'b00;
        bus.unit_valid_out = 1'b1;
        #1;
        chk("fair_rsp0", 32'(bus.rsp_valid), 32'h1);
        step();
        chk("fair_rsp1", 32'(bus.rsp_valid), 32'h2);
        step();

        // Protocol error: result with nothing outstanding
        chk("perr_rsp_valid",     32'(bus.rsp_valid),     32'h0);
        chk("perr_unit_ready_in", 32'(bus.unit_ready_in), 32'h0);
        chk("perr_err_before",    32'(bus.err),           32'h0);
        step();
        chk("perr_err_set", 32'(bus.err), 32'h1);
        bus.unit_valid_out = 1'b0;
        step();
        step();
        chk("perr_err_sticky", 32'(bus.err), 32'h1);

        // Async reset with two operations outstanding and priority at req1
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b01;
        step();
        bus.req_valid      = 2'b11;
        bus.unit_valid_out = 1'b1;
        #1;
        chk("mrst_full", 32'(bus.req_ready), 32'h0);
        reset = 1'b1;
        #1;
        chk("mrst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mrst_err",       32'(bus.err),       32'h0);
        @(negedge clk);
        reset              = 1'b0;
        bus.unit_valid_out = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("post_rst_data",      bus.unit_data,      c_d0);
        chk("post_rst_err",       32'(bus.err),       32'h0);
        step();
        chk("post_rst_second", 32'(bus.req_ready), 32'h2);
        step();
        chk("post_rst_full", 32'(bus.req_ready), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fpu_cvt_arbiter.md
Name: fpu_cvt_arbiter

Overview:
- Shares one float/int conversion unit (valid/ready in, valid/ready out, single result register) between N_REQ requesters, e.g. the integer pipeline's FCVT issue port and a vector/microcode sequencer.
- Selects requesters round-robin and forwards op, rm and operand to the unit.
- Records which requester owns each in-flight operation and routes the result and flags back to that requester only.
- Sits between the FPU decode stage and the conversion datapath.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- TAG_DEPTH, 2, maximum outstanding operations tracked (power of 2, ≥1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operation valid
- req_ready  out  N_REQ  per-requester accept
- req_op  in  5*N_REQ  FPU op code, requester i at [5i+4:5i]
- req_rm  in  3*N_REQ  rounding mode, requester i at [3i+2:3i]
- req_data  in  DATA_W*N_REQ  operand, requester i at slice i
- unit_valid_in  out  1  operation to unit valid
- unit_ready_out  in  1  unit accepts operation
- unit_op  out  5  granted op
- unit_rm  out  3  granted rm
- unit_data  out  DATA_W  granted operand
- unit_valid_out  in  1  unit result valid
- unit_ready_in  out  1  result consumed
- unit_result  in  DATA_W  unit result
- unit_flags  in  5  unit exception flags {NV,DZ,OF,UF,NX}
- rsp_valid  out  N_REQ  one-hot result valid
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_result  out  DATA_W  broadcast result (= unit_result)
- rsp_flags  out  5  broadcast flags (= unit_flags)
- owner  out  $clog2(N_REQ)  requester index of current result (tag FIFO head)
- err  out  1  sticky protocol error

Behaviour:
- State: rr_ptr (next-priority index), tag FIFO (TAG_DEPTH entries of requester index, wr_ptr, rd_ptr, count 0..TAG_DEPTH), err.
- Reset (async, active-high): rr_ptr=0, FIFO empty (ptrs=0, count=0), err=0. While reset is high, all req_ready=0, unit_valid_in=0, rsp_valid=0, unit_ready_in=0.
- Grant, combinational: first i with req_valid[i], searching from rr_ptr upward with modulo-N_REQ wrap. gnt_any = OR of req_valid.
- can_issue = (count<TAG_DEPTH) or pop.
- unit_valid_in = gnt_any & can_issue. unit_op/rm/data = slices of the granted requester; all zeros when there is no grant.
- req_ready[g] = can_issue & unit_ready_out for the granted g only; 0 for every other requester. req_ready never depends on unit_valid_in loops.
- issue = unit_valid_in & unit_ready_out. On issue: push g into the FIFO and set rr_ptr = (g+1) mod N_REQ. With no issue, rr_ptr holds.
- Response: rsp_valid[owner] = unit_valid_out & (count≠0); all other bits 0. unit_ready_in = (count≠0) & rsp_ready[owner].
- pop = unit_valid_out & unit_ready_in. On pop: rd_ptr++.
- Simultaneous push and pop: count is unchanged and both pointers advance, including when the FIFO is full (full plus pop allows issue).
- Pointers wrap modulo TAG_DEPTH.
- Added latency: zero in both directions (pure combinational forwarding). Throughput is one operation per cycle when the unit and requesters allow it.
- Requester contract: req_op/rm/data are held stable while req_valid=1 and req_ready=0. The arbiter may re-select a different requester in a later cycle if a higher-priority requester raises valid; grant is not sticky.
- Error: unit_valid_out=1 while count=0 sets err=1. err stays set until reset. Such a result is never acknowledged (unit_ready_in=0).
- Reset mid-operation: all tracking is discarded. The unit is reset on the same reset, so no stale results return.
- Responses are returned strictly in issue order; the unit is in-order.

Test Plan:
- Single requester: req_valid=01, op=CVTFI, data=0x40490fdb, unit ready → unit_valid_in=1 same cycle with unit_data=0x40490fdb. Result 0x00000003, flags=00001 next cycle → rsp_valid=01, owner=0, rsp_result=0x00000003.
- Both requesters valid continuously, unit always ready, TAG_DEPTH=2, responses accepted every cycle → issue order 0,1,0,1… with rr_ptr alternating; responses return to owners in the same order.
- Backpressure: rsp_ready=00 for 4 cycles with the unit holding its result → count reaches 2, req_ready=00. Raise rsp_ready[owner] → pop and new issue occur in the same cycle, count stays 2.
- Grant fairness: req0 valid always; req1 raises valid one cycle after req0 issues → req1 is granted next (rr_ptr=1) even though req0 is still valid.
- Protocol error: unit_valid_out=1 with an empty FIFO → err=1 next edge, unit_ready_in=0, rsp_valid=00. err stays 1 until reset.
- Async reset asserted mid-stream with count=2 → immediately req_ready=00, rsp_valid=00. After release: count=0, rr_ptr=0, err=0, and the first grant goes to req0 when both are valid.
